// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory-port arbiter and its response tracker.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    // Access sizes carried on the memory port
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Who issued the command occupying a response-pipeline slot
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_FETCH,
        OWN_LOAD,
        OWN_STORE
    } owner_t;

    // One slot of the response pipeline
    typedef struct packed {
        owner_t owner;
        logic   kill;
    } resp_entry_t;

    // Registered memory command payload (mem_en is kept separately)
    typedef struct packed {
        logic              we;
        logic [1:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    // True for owners that expect read data back
    function automatic logic is_read_owner(input owner_t o);
        return (o == OWN_FETCH) || (o == OWN_LOAD);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_resp.sv
// Response tracker: owner/kill shift register aligned to memory read latency,
// fetch squash on jump, and routing of returned read data.
module mem_resp_tracker
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  owner_t            issue_owner,
    input  logic              jump,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] instruction,
    output logic              r_rvalid,
    output logic [DATA_W-1:0] data_in,
    output logic              busy
);

    // Slot 0 mirrors the command on the port; slot MEM_LAT lines up with mem_rdata
    localparam int unsigned DEPTH = MEM_LAT + 1;

    resp_entry_t pipe_q [DEPTH];
    resp_entry_t pipe_d [DEPTH];
    resp_entry_t head;

    // Next pipeline contents: shift by one, kill every fetch on jump
    always_comb begin
        pipe_d[0].owner = issue_owner;
        pipe_d[0].kill  = jump && (issue_owner == OWN_FETCH);
        for (int unsigned i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
            if (jump && (pipe_q[i-1].owner == OWN_FETCH)) begin
                pipe_d[i].kill = 1'b1;
            end
        end
    end

    // Pipeline register; reset drops everything in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '{owner: OWN_NONE, kill: 1'b0};
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign head = pipe_q[DEPTH-1];

    // Route returning data; a jump in the return cycle also squashes a fetch
    always_comb begin
        f_rvalid    = 1'b0;
        r_rvalid    = 1'b0;
        instruction = '0;
        data_in     = '0;
        if ((head.owner == OWN_FETCH) && !head.kill && !jump) begin
            f_rvalid    = 1'b1;
            instruction = mem_rdata;
        end else if (head.owner == OWN_LOAD) begin
            r_rvalid = 1'b1;
            data_in  = mem_rdata;
        end
    end

    // Any read (including squashed fetches) still owed by the memory
    always_comb begin
        busy = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (is_read_owner(pipe_q[i].owner)) begin
                busy = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Three-way arbiter (fetch/load/store) onto a single-port synchronous memory.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] instruction,
    input  logic              r_req,
    input  logic [ADDR_W-1:0] r_addr,
    input  logic [1:0]        r_size,
    output logic              r_gnt,
    output logic              r_rvalid,
    output logic [DATA_W-1:0] DATA_in,
    input  logic              w_req,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic [1:0]        w_size,
    output logic              w_gnt,
    input  logic              jump,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_size,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             fetch_starved;
    owner_t           issue_owner;
    mem_cmd_t         cmd_d;
    mem_cmd_t         cmd_q;

    // Fixed priority store > load > fetch, overridden by a starved fetch; no grants in reset
    always_comb begin
        f_gnt         = 1'b0;
        r_gnt         = 1'b0;
        w_gnt         = 1'b0;
        fetch_starved = f_req && (starve_cnt == CNT_W'(STARVE_MAX));
        if (reset) begin
            if (fetch_starved) begin
                f_gnt = 1'b1;
            end else if (w_req) begin
                w_gnt = 1'b1;
            end else if (r_req) begin
                r_gnt = 1'b1;
            end else if (f_req) begin
                f_gnt = 1'b1;
            end
        end
    end

    // Winner's command and response owner; idle cycles hold the previous command fields
    always_comb begin
        issue_owner = OWN_NONE;
        cmd_d       = cmd_q;
        if (w_gnt) begin
            cmd_d.we    = 1'b1;
            cmd_d.size  = w_size;
            cmd_d.addr  = w_addr;
            cmd_d.wdata = w_data;
        end else if (r_gnt) begin
            issue_owner = OWN_LOAD;
            cmd_d.we    = 1'b0;
            cmd_d.size  = r_size;
            cmd_d.addr  = r_addr;
        end else if (f_gnt) begin
            issue_owner = OWN_FETCH;
            cmd_d.we    = 1'b0;
            cmd_d.size  = SZ_WORD;
            cmd_d.addr  = f_addr;
        end
    end

    // Memory command register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_en <= 1'b0;
            cmd_q  <= '{we: 1'b0, size: SZ_WORD, addr: '0, wdata: '0};
        end else begin
            mem_en <= f_gnt || r_gnt || w_gnt;
            cmd_q  <= cmd_d;
        end
    end

    assign mem_we    = cmd_q.we;
    assign mem_size  = cmd_q.size;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;

    // Consecutive cycles a pending fetch has been denied, saturating
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (f_req && !f_gnt) begin
            if (starve_cnt != CNT_W'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    mem_resp_tracker #(
        .MEM_LAT (MEM_LAT)
    ) u_resp (
        .clk         (clk),
        .reset       (reset),
        .issue_owner (issue_owner),
        .jump        (jump),
        .mem_rdata   (mem_rdata),
        .f_rvalid    (f_rvalid),
        .instruction (instruction),
        .r_rvalid    (r_rvalid),
        .data_in     (DATA_in),
        .busy        (busy)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: grant table, directed corner sequences and
// randomized traffic checked against a queue-based response model.
module tb_mem_port_arbiter;

    localparam int unsigned MEM_LAT    = 2;
    localparam int unsigned STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req, r_req, w_req, jump;
    logic [31:0] f_addr, r_addr, w_addr, w_data;
    logic [1:0]  r_size, w_size;
    logic        f_gnt, r_gnt, w_gnt, f_rvalid, r_rvalid, busy, mem_en, mem_we;
    logic [31:0] instruction, DATA_in, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_size;

    mem_port_arbiter #(
        .MEM_LAT    (MEM_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .f_req       (f_req),
        .f_addr      (f_addr),
        .f_gnt       (f_gnt),
        .f_rvalid    (f_rvalid),
        .instruction (instruction),
        .r_req       (r_req),
        .r_addr      (r_addr),
        .r_size      (r_size),
        .r_gnt       (r_gnt),
        .r_rvalid    (r_rvalid),
        .DATA_in     (DATA_in),
        .w_req       (w_req),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .w_size      (w_size),
        .w_gnt       (w_gnt),
        .jump        (jump),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_size    (mem_size),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Unwritten memory words have an address-derived value; 0x100 holds addi x1,x0,5
    function automatic logic [31:0] init_val(input logic [7:0] idx);
        if (idx == 8'h40) return 32'h0050_0093;
        return {8'hA5, idx, ~idx, idx ^ 8'h3C};
    endfunction

    // Synchronous memory: full-word writes (size ignored), reads valid MEM_LAT cycles later
    logic [31:0] mem_wr [logic [7:0]];
    logic [31:0] rd_pipe [MEM_LAT];
    always @(posedge clk) begin : mem_model
        logic [31:0] rd;
        rd = 32'hDEAD_BEEF;
        if (mem_en && !mem_we)
            rd = mem_wr.exists(mem_addr[9:2]) ? mem_wr[mem_addr[9:2]] : init_val(mem_addr[9:2]);
        if (mem_en && mem_we)
            mem_wr[mem_addr[9:2]] = mem_wdata;
        rd_pipe[0] <= rd;
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    // ---------------- reference model ----------------
    typedef struct {
        longint      due;
        bit          fetch;
        bit          killed;
        logic [31:0] data;
    } resp_t;

    int          checks = 0;
    int          errors = 0;
    longint      cyc = 0;
    int          starve;
    resp_t       q[$];
    logic [31:0] ref_wr [logic [7:0]];
    logic        exp_en, exp_we;
    logic [1:0]  exp_size;
    logic [31:0] exp_addr, exp_wdata;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (ref_wr.exists(a[9:2])) return ref_wr[a[9:2]];
        return init_val(a[9:2]);
    endfunction

    task automatic model_reset();
        q.delete();
        starve    = 0;
        exp_en    = 1'b0;
        exp_we    = 1'b0;
        exp_size  = 2'b10;
        exp_addr  = '0;
        exp_wdata = '0;
    endtask

    // One cycle of expected behaviour, evaluated from the current inputs
    task automatic model_step();
        logic [2:0] g;
        resp_t      e;
        bit         fv, rv, exp_busy;
        g = 3'b000;
        if (f_req && starve >= int'(STARVE_MAX)) g = 3'b100;
        else if (w_req) g = 3'b001;
        else if (r_req) g = 3'b010;
        else if (f_req) g = 3'b100;
        chk("grant", 72'({f_gnt, r_gnt, w_gnt}), 72'(g));
        chk("mem_cmd", 72'({mem_en, mem_we, mem_size, mem_addr, mem_wdata}),
            72'({exp_en, exp_we, exp_size, exp_addr, exp_wdata}));
        exp_busy = (q.size() != 0);
        chk("busy", 72'(busy), 72'(exp_busy));
        fv = 1'b0; rv = 1'b0;
        e  = '{0, 1'b0, 1'b0, 32'd0};
        if (q.size() != 0 && q[0].due == cyc) begin
            e = q.pop_front();
            if (e.fetch) fv = !e.killed && !jump;
            else rv = 1'b1;
        end
        chk("rvalid", 72'({f_rvalid, r_rvalid}), 72'({fv, rv}));
        if (fv) chk("instruction", 72'(instruction), 72'(e.data));
        if (rv) chk("DATA_in", 72'(DATA_in), 72'(e.data));
        if (jump) foreach (q[i]) if (q[i].fetch) q[i].killed = 1'b1;
        exp_en = (g != 3'b000);
        e.due  = cyc + longint'(MEM_LAT) + 1;
        case (g)
            3'b001: begin
                exp_we = 1'b1; exp_size = w_size; exp_addr = w_addr; exp_wdata = w_data;
                ref_wr[w_addr[9:2]] = w_data;
            end
            3'b010: begin
                exp_we = 1'b0; exp_size = r_size; exp_addr = r_addr;
                e.fetch = 1'b0; e.killed = 1'b0; e.data = ref_read(r_addr);
                q.push_back(e);
            end
            3'b100: begin
                exp_we = 1'b0; exp_size = 2'b10; exp_addr = f_addr;
                e.fetch = 1'b1; e.killed = jump; e.data = ref_read(f_addr);
                q.push_back(e);
            end
            default: ;
        endcase
        if (f_req && g != 3'b100) begin
            if (starve < int'(STARVE_MAX)) starve++;
        end else begin
            starve = 0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] rnd_addr();
        return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    endfunction

    task automatic sample();
        @(negedge clk);
        model_step();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic drive_reqs(input logic [2:0] frw);
        f_req = frw[2]; r_req = frw[1]; w_req = frw[0];
        f_addr = rnd_addr(); r_addr = rnd_addr(); w_addr = rnd_addr();
        w_data = $urandom; r_size = 2'($urandom_range(0, 2)); w_size = 2'($urandom_range(0, 2));
    endtask

    task automatic drain();
        f_req = 1'b0; r_req = 1'b0; w_req = 1'b0; jump = 1'b0;
        repeat (MEM_LAT + 3) step();
    endtask

    typedef struct {
        logic [2:0] req;   // {f, r, w}
        logic [2:0] gnt;   // {f, r, w}
    } vec_t;
    vec_t tbl [13];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int         fc, rc, denied;
        bit         got;
        logic [2:0] g;
        logic [2:0] simul_exp [3];
        bit         gf, gr, gw;

        // Grant table; starvation count evolves row to row starting from zero
        tbl[0]  = '{3'b000, 3'b000};
        tbl[1]  = '{3'b111, 3'b001};
        tbl[2]  = '{3'b011, 3'b001};
        tbl[3]  = '{3'b010, 3'b010};
        tbl[4]  = '{3'b001, 3'b001};
        tbl[5]  = '{3'b110, 3'b010};
        tbl[6]  = '{3'b100, 3'b100};
        tbl[7]  = '{3'b101, 3'b001};
        tbl[8]  = '{3'b111, 3'b001};
        tbl[9]  = '{3'b110, 3'b010};
        tbl[10] = '{3'b111, 3'b001};
        tbl[11] = '{3'b111, 3'b100};
        tbl[12] = '{3'b111, 3'b001};
        simul_exp[0] = 3'b001;
        simul_exp[1] = 3'b010;
        simul_exp[2] = 3'b100;

        // Reset held with every requester active
        reset = 1'b0;
        jump  = 1'b0;
        drive_reqs(3'b111);
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_gnt", 72'({f_gnt, r_gnt, w_gnt}), 72'(3'b000));
            chk("rst_flags", 72'({f_rvalid, r_rvalid, busy, mem_en, mem_we}), 72'(5'b00000));
            chk("rst_mem_size", 72'(mem_size), 72'(2'b10));
            chk("rst_mem_addr_wdata", 72'({mem_addr, mem_wdata}), 72'(64'd0));
            chk("rst_resp_data", 72'({instruction, DATA_in}), 72'(64'd0));
            advance();
        end
        reset = 1'b1;
        sample();
        chk("first_grant_store", 72'({f_gnt, r_gnt, w_gnt}), 72'(3'b001));
        advance();
        drain();

        // Table-driven arbitration vectors
        for (int i = 0; i < 13; i++) begin
            drive_reqs(tbl[i].req);
            sample();
            chk($sformatf("vec%0d_gnt", i), 72'({f_gnt, r_gnt, w_gnt}), 72'(tbl[i].gnt));
            advance();
        end
        drain();

        // Single fetch of 0x100
        f_req = 1'b1; f_addr = 32'h100;
        sample();
        chk("fetch_gnt_c0", 72'(f_gnt), 72'(1'b1));
        advance();
        f_req = 1'b0;
        sample();
        chk("fetch_cmd_c1", 72'({mem_en, mem_we, mem_addr}), 72'({1'b1, 1'b0, 32'h100}));
        advance();
        repeat (MEM_LAT - 1) step();
        sample();
        chk("fetch_resp", 72'({f_rvalid, instruction}), 72'({1'b1, 32'h0050_0093}));
        advance();
        drain();

        // Simultaneous requests: store, load, fetch on consecutive cycles
        drive_reqs(3'b111);
        rc = 0;
        for (int i = 0; i < 3; i++) begin
            sample();
            g = {f_gnt, r_gnt, w_gnt};
            chk($sformatf("simul_gnt%0d", i), 72'(g), 72'(simul_exp[i]));
            if (r_rvalid) rc++;
            advance();
            if (g[0]) w_req = 1'b0;
            if (g[1]) r_req = 1'b0;
            if (g[2]) f_req = 1'b0;
        end
        repeat (MEM_LAT + 3) begin
            sample();
            if (r_rvalid) rc++;
            advance();
        end
        chk("simul_one_load_resp", 72'(rc), 72'(1));
        drain();

        // Starvation: continuous loads, fetch held; two rounds show the counter restarts
        r_req = 1'b1; r_addr = rnd_addr(); r_size = 2'b10;
        f_req = 1'b1; f_addr = 32'h300;
        for (int round = 0; round < 2; round++) begin
            denied = 0;
            got    = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (!got) begin
                    sample();
                    if (f_gnt) got = 1'b1;
                    else denied++;
                    advance();
                end
            end
            chk($sformatf("starve_denials_r%0d", round), 72'(denied), 72'(STARVE_MAX));
            chk($sformatf("starve_granted_r%0d", round), 72'(got), 72'(1'b1));
        end
        drain();

        // Jump squash: fetch, load, fetch, then jump
        fc = 0; rc = 0;
        f_req = 1'b1; f_addr = 32'h200;
        sample();
        chk("jmp_fetch0_gnt", 72'(f_gnt), 72'(1'b1));
        if (f_rvalid) fc++;
        advance();
        f_req = 1'b0; r_req = 1'b1; r_addr = 32'h80; r_size = 2'b10;
        sample();
        chk("jmp_load_gnt", 72'(r_gnt), 72'(1'b1));
        if (f_rvalid) fc++;
        if (r_rvalid) rc++;
        advance();
        r_req = 1'b0; f_req = 1'b1; f_addr = 32'h204;
        sample();
        chk("jmp_fetch1_gnt", 72'(f_gnt), 72'(1'b1));
        if (f_rvalid) fc++;
        if (r_rvalid) rc++;
        advance();
        f_req = 1'b0; jump = 1'b1;
        sample();
        if (f_rvalid) fc++;
        if (r_rvalid) rc++;
        advance();
        jump = 1'b0;
        repeat (MEM_LAT + 2) begin
            sample();
            if (f_rvalid) fc++;
            if (r_rvalid) rc++;
            advance();
        end
        chk("jmp_no_fetch_resp", 72'(fc), 72'(0));
        chk("jmp_load_resp", 72'(rc), 72'(1));
        drain();

        // Async reset one cycle after a load grant
        r_req = 1'b1; r_addr = rnd_addr(); r_size = 2'b01;
        sample();
        chk("rst_mid_load_gnt", 72'(r_gnt), 72'(1'b1));
        advance();
        r_req = 1'b0;
        sample();
        reset = 1'b0;
        #1;
        chk("rst_mid_busy_cleared", 72'(busy), 72'(1'b0));
        chk("rst_mid_no_rvalid", 72'(r_rvalid), 72'(1'b0));
        model_reset();
        rc = 0;
        advance();
        @(negedge clk);
        if (r_rvalid) rc++;
        advance();
        reset = 1'b1;
        repeat (MEM_LAT + 3) begin
            sample();
            if (r_rvalid) rc++;
            advance();
        end
        chk("rst_mid_no_stale_resp", 72'(rc), 72'(0));
        drain();

        // Randomized traffic: requests held until granted, occasional withdrawal and jump
        for (int n = 0; n < 600; n++) begin
            sample();
            gf = f_gnt; gr = r_gnt; gw = w_gnt;
            advance();
            if (f_req && !gf) begin
                if ($urandom_range(0, 15) == 0) f_req = 1'b0;
            end else begin
                f_req = ($urandom_range(0, 2) != 0); f_addr = rnd_addr();
            end
            if (r_req && !gr) begin
                if ($urandom_range(0, 15) == 0) r_req = 1'b0;
            end else begin
                r_req = ($urandom_range(0, 1) != 0); r_addr = rnd_addr();
                r_size = 2'($urandom_range(0, 2));
            end
            if (w_req && !gw) begin
                if ($urandom_range(0, 15) == 0) w_req = 1'b0;
            end else begin
                w_req = ($urandom_range(0, 2) == 0); w_addr = rnd_addr();
                w_data = $urandom; w_size = 2'($urandom_range(0, 2));
            end
            jump = ($urandom_range(0, 15) == 0);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between three requesters of the async RISC-V core: instruction fetch, load (execute read path) and store (retire write path).
- Sits between the core top level and a unified memory model.
- Selects one command per cycle and registers it onto the memory port.
- Tracks ownership of in-flight reads and routes returned data back to fetch or load.
- Squashes stale fetch responses on a retire jump.

Parameters:
- MEM_LAT, 1, memory read latency in cycles from command on port to mem_rdata valid (1..4).
- STARVE_MAX, 4, consecutive cycles fetch may be denied before it is forced to top priority.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- f_req  in  1  fetch request, held until f_gnt
- f_addr  in  32  fetch address (i_address)
- f_gnt  out  1  fetch request accepted this cycle
- f_rvalid  out  1  instruction word valid
- instruction  out  32  fetched word
- r_req  in  1  load request, held until r_gnt
- r_addr  in  32  load address (read_address)
- r_size  in  2  00 byte, 01 half, 10 word
- r_gnt  out  1  load accepted
- r_rvalid  out  1  load data valid
- DATA_in  out  32  load data
- w_req  in  1  store request, held until w_gnt
- w_addr  in  32  store address (write_address)
- w_data  in  32  store data (DATA_out)
- w_size  in  2  store size
- w_gnt  out  1  store accepted
- jump  in  1  retire redirect; kills outstanding fetch responses
- mem_en  out  1  memory command valid
- mem_we  out  1  1 = write
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_size  out  2  access size
- mem_rdata  in  32  memory read data, MEM_LAT cycles after read command
- busy  out  1  any read in flight

Behaviour:
- Reset (reset=0, async): mem_en, mem_we, f_gnt, r_gnt, w_gnt, f_rvalid, r_rvalid, busy = 0; mem_addr, mem_wdata, instruction, DATA_in = 0; mem_size = 2'b10; starvation counter = 0; owner pipeline all OWN_NONE.
- Reset mid-operation drops every in-flight read; no rvalid may follow reset release for a pre-reset command.
- Arbitration (combinational in cycle t):
  - Default priority: store > load > fetch.
  - If starve_cnt == STARVE_MAX and f_req=1, fetch wins instead.
  - Exactly one gnt is high when any req is high, none otherwise.
  - Requester must hold req and its payload stable until gnt; dropping req before gnt is legal (request withdrawn).
- Command issue: the winner's command is registered at the end of cycle t; mem_en=1 in cycle t+1 with mem_we=1 for store, else 0.
  - Fetch always drives mem_size=2'b10.
  - Idle cycles give mem_en=0 and hold the other mem_* values.
- Starvation counter, updated each cycle:
  - Increment (saturating at STARVE_MAX) when f_req=1 and f_gnt=0.
  - Clear when f_gnt=1 or f_req=0.
- Owner pipeline: MEM_LAT+1 deep shift register of {owner, kill}. A read command issued at t+1 returns at t+1+MEM_LAT, where mem_rdata is routed combinationally:
  - OWN_FETCH with kill=0: f_rvalid=1, instruction=mem_rdata.
  - OWN_LOAD: r_rvalid=1, DATA_in=mem_rdata.
  - Stores insert OWN_NONE and produce no response.
- jump=1 sets kill on every OWN_FETCH entry in the pipeline and on a fetch granted in the same cycle. Those responses are suppressed (f_rvalid stays 0). Load entries are unaffected.
- At most one rvalid per cycle; responses return strictly in issue order.
- Back-to-back grants every cycle are legal (fully pipelined, throughput 1/cycle).
- busy=1 while any pipeline entry is OWN_FETCH or OWN_LOAD.
- No alignment checking; address and size pass through unchanged.

Decomposition:
- my_pkg additions:
  - typedef enum logic [1:0] owner_t {OWN_NONE, OWN_FETCH, OWN_LOAD, OWN_STORE}
  - constants SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10
- Sub-module mem_resp_tracker (owner/kill shift register, kill-on-jump, response routing); arbitration, starvation and command registers stay in the top module.

Test Plan:
- Reset check: hold reset=0 with all reqs=1 -> all gnt/rvalid/mem_en=0, mem_size=2'b10; release -> first grant is w_gnt.
- Single fetch, MEM_LAT=1: f_req, f_addr=0x100, memory returns 0x00500093 -> f_gnt cycle 0, mem_en/addr=0x100 cycle 1, f_rvalid with instruction=0x00500093 cycle 2.
- Simultaneous requests: f_req, r_req, w_req all =1 in the same cycle -> grant order store, load, fetch over 3 consecutive cycles; one load response only, routed to DATA_in.
- Starvation, STARVE_MAX=4: continuous r_req with f_req held -> fetch denied 4 cycles, granted on the 5th; counter then returns to 0.
- Jump squash, MEM_LAT=2: grant fetches to 0x200 and 0x204, assert jump the cycle after the second grant -> neither f_rvalid appears; a load issued between them still returns r_rvalid.
- Async reset mid-flight: reset=0 one cycle after a load grant -> r_rvalid never asserts; busy=0 immediately.
